// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto NUM_VOICES oscillator
// voices (retrigger / free / oldest-steal) and converts MIDI notes to PHASE_INCR.
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int VW         = $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  evt_valid,
  output logic                  evt_ready,
  input  logic                  evt_on,
  input  logic [6:0]            evt_note,
  output logic                  cfg_valid,
  input  logic                  cfg_ready,
  output logic [VW-1:0]         cfg_voice,
  output logic                  cfg_gate,
  output logic [31:0]           cfg_phase_incr,
  output logic [NUM_VOICES-1:0] voice_active
);

  typedef enum logic [2:0] {IDLE, SEARCH, DIVIDE, CALC, EMIT} state_t;
  state_t state, state_d;

  logic                  lat_on;
  logic [6:0]            lat_note;
  logic                  off_fetch;
  logic                  off_hit;
  logic [6:0]            rem;
  logic [3:0]            oct;

  logic [NUM_VOICES-1:0] v_active;
  logic [6:0]            v_note [NUM_VOICES];
  logic [31:0]           v_incr [NUM_VOICES];
  logic [3:0]            v_age  [NUM_VOICES];

  logic                  hit;
  logic [VW-1:0]         hit_idx;
  logic                  has_free;
  logic [VW-1:0]         free_idx;
  logic [VW-1:0]         old_idx;
  logic [3:0]            old_age;
  logic [VW-1:0]         on_idx;

  // Phase increments for MIDI notes 120..131 (octave 10) at 48 kHz.
  function automatic logic [31:0] base_rom(input logic [3:0] s);
    case (s)
      4'd0:    base_rom = 32'd749115497;
      4'd1:    base_rom = 32'd793660223;
      4'd2:    base_rom = 32'd840853716;
      4'd3:    base_rom = 32'd890853479;
      4'd4:    base_rom = 32'd943826384;
      4'd5:    base_rom = 32'd999949221;
      4'd6:    base_rom = 32'd1059409296;
      4'd7:    base_rom = 32'd1122405051;
      4'd8:    base_rom = 32'd1189146729;
      4'd9:    base_rom = 32'd1259857073;
      4'd10:   base_rom = 32'd1334772073;
      4'd11:   base_rom = 32'd1414141751;
      default: base_rom = '0;
    endcase
  endfunction

  // Strict '>' from voice 0 keeps the lowest index on age ties.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    old_idx  = '0;
    old_age  = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!hit && v_active[i] && (v_note[i] == lat_note)) begin
        hit     = 1'b1;
        hit_idx = VW'(i);
      end
      if (!has_free && !v_active[i]) begin
        has_free = 1'b1;
        free_idx = VW'(i);
      end
      if (v_age[i] > old_age) begin
        old_age = v_age[i];
        old_idx = VW'(i);
      end
    end
    on_idx = hit ? hit_idx : (has_free ? free_idx : old_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    evt_ready = 1'b0;
    cfg_valid = 1'b0;
    case (state)
      IDLE: begin
        evt_ready = 1'b1;
        if (evt_valid) state_d = SEARCH;
      end
      SEARCH: begin
        if (lat_on)         state_d = DIVIDE;
        else if (off_fetch) state_d = off_hit ? EMIT : IDLE;
      end
      DIVIDE: if (rem < 7'd12) state_d = CALC;
      CALC:   state_d = EMIT;
      EMIT: begin
        cfg_valid = 1'b1;
        if (cfg_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Note-off spends a second SEARCH cycle reading the stored incr through the
  // registered target index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_on         <= 1'b0;
      lat_note       <= '0;
      off_fetch      <= 1'b0;
      off_hit        <= 1'b0;
      rem            <= '0;
      oct            <= '0;
      cfg_voice      <= '0;
      cfg_gate       <= 1'b0;
      cfg_phase_incr <= '0;
    end else begin
      case (state)
        IDLE: if (evt_valid) begin
          lat_on    <= evt_on;
          lat_note  <= evt_note;
          off_fetch <= 1'b0;
        end
        SEARCH: begin
          if (lat_on) begin
            cfg_voice <= on_idx;
            cfg_gate  <= 1'b1;
            rem       <= lat_note;
            oct       <= '0;
          end else if (!off_fetch) begin
            off_fetch <= 1'b1;
            off_hit   <= hit;
            if (hit) cfg_voice <= hit_idx;
          end else if (off_hit) begin
            cfg_gate       <= 1'b0;
            cfg_phase_incr <= v_incr[cfg_voice];
          end
        end
        DIVIDE: if (rem >= 7'd12) begin
          rem <= rem - 7'd12;
          oct <= oct + 4'd1;
        end
        CALC: cfg_phase_incr <= base_rom(rem[3:0]) >> (4'd10 - oct);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_active <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        v_note[i] <= '0;
        v_incr[i] <= '0;
        v_age[i]  <= '0;
      end
    end else if (state == EMIT && cfg_ready) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (VW'(i) == cfg_voice) begin
          v_active[i] <= lat_on;
          if (lat_on) begin
            v_note[i] <= lat_note;
            v_incr[i] <= cfg_phase_incr;
            v_age[i]  <= '0;
          end
        end else if (lat_on && v_active[i] && (v_age[i] != 4'd15)) begin
          v_age[i] <= v_age[i] + 4'd1;
        end
      end
    end
  end

  assign voice_active = v_active;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, stealing, retrigger, note-off,
// latency per octave, cfg back-pressure and asynchronous reset abort.
module tb_voice_allocator;

  localparam int NV = 8;
  localparam int VW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          evt_valid;
  logic          evt_ready;
  logic          evt_on;
  logic [6:0]    evt_note;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [VW-1:0] cfg_voice;
  logic          cfg_gate;
  logic [31:0]   cfg_phase_incr;
  logic [NV-1:0] voice_active;

  int n_cmp = 0;
  int n_err = 0;

  // floor(f(120+s) * 2^32 / 48000)
  logic [31:0] base_tab [12] = '{32'd749115497, 32'd793660223, 32'd840853716,
                                 32'd890853479, 32'd943826384, 32'd999949221,
                                 32'd1059409296, 32'd1122405051, 32'd1189146729,
                                 32'd1259857073, 32'd1334772073, 32'd1414141751};

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_on         (evt_on),
    .evt_note       (evt_note),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_voice      (cfg_voice),
    .cfg_gate       (cfg_gate),
    .cfg_phase_incr (cfg_phase_incr),
    .voice_active   (voice_active)
  );

  function automatic logic [31:0] model_incr(input int note);
    logic [31:0] b;
    b = base_tab[note % 12];
    return b >> (10 - note / 12);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one event, wait for accept (edge E0), then count edges until
  // cfg_valid rises or evt_ready returns.
  task automatic send_evt(input bit on, input int note, output int lat, output bit saw);
    int n;
    @(negedge clk);
    evt_on    = on;
    evt_note  = 7'(note);
    evt_valid = 1'b1;
    n = 0;
    while (!evt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 evt_valid = 1'b0;
    lat = 0;
    saw = 1'b0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (cfg_valid) begin
        saw = 1'b1;
        break;
      end
      if (evt_ready) break;
    end
  endtask

  task automatic do_write(input string tag, input bit on, input int note, input int exp_lat,
                          input int exp_voice, input bit exp_gate, input logic [31:0] exp_incr);
    int lat;
    bit saw;
    send_evt(on, note, lat, saw);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    if (saw) begin
      check({tag, ".voice"}, 32'(cfg_voice), 32'(exp_voice));
      check({tag, ".gate"}, 32'(cfg_gate), 32'(exp_gate));
      check({tag, ".incr"}, cfg_phase_incr, exp_incr);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_miss(input string tag, input int note);
    int lat;
    bit saw;
    send_evt(1'b0, note, lat, saw);
    check({tag, ".no_cfg"}, 32'(saw), 32'd0);
    check({tag, ".ready_lat"}, 32'(lat), 32'd2);
    check({tag, ".ready"}, 32'(evt_ready), 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit saw;
    bit stray;

    rst_n     = 1'b0;
    evt_valid = 1'b0;
    evt_on    = 1'b0;
    evt_note  = '0;
    cfg_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.evt_ready", 32'(evt_ready), 32'd1);
    check("rst.cfg_valid", 32'(cfg_valid), 32'd0);
    check("rst.cfg_voice", 32'(cfg_voice), 32'd0);
    check("rst.cfg_gate", 32'(cfg_gate), 32'd0);
    check("rst.cfg_incr", cfg_phase_incr, 32'd0);
    check("rst.active", 32'(voice_active), 32'd0);

    // First note-on, A4
    do_write("on69", 1'b1, 69, 8, 0, 1'b1, 32'd39370533);
    check("on69.active", 32'(voice_active), 32'h01);
    check("on69.ready", 32'(evt_ready), 32'd1);

    // Allocate three voices, release the middle one
    pulse_reset();
    do_write("on60", 1'b1, 60, 8, 0, 1'b1, 32'd23409859);
    do_write("on62", 1'b1, 62, 8, 1, 1'b1, 32'd26276678);
    do_write("on64", 1'b1, 64, 8, 2, 1'b1, 32'd29494574);
    check("3on.active", 32'(voice_active), 32'h07);
    do_write("off62", 1'b0, 62, 2, 1, 1'b0, 32'd26276678);
    check("off62.active", 32'(voice_active), 32'h05);

    // Fill all voices then steal the two oldest
    pulse_reset();
    for (int n = 60; n <= 67; n++)
      do_write("fill", 1'b1, n, 8, n - 60, 1'b1, model_incr(n));
    check("fill.active", 32'(voice_active), 32'hFF);
    do_write("steal72", 1'b1, 72, 9, 0, 1'b1, 32'd46819718);
    do_write("steal74", 1'b1, 74, 9, 1, 1'b1, 32'd52553357);
    check("steal.active", 32'(voice_active), 32'hFF);

    // Retrigger 64 twice: same voice, age restarts, oldest is now voice 2
    do_write("retrig1", 1'b1, 64, 8, 4, 1'b1, 32'd29494574);
    do_write("retrig2", 1'b1, 64, 8, 4, 1'b1, 32'd29494574);
    do_write("steal81", 1'b1, 81, 9, 2, 1'b1, 32'd78741067);
    do_write("off64", 1'b0, 64, 2, 4, 1'b0, 32'd29494574);
    check("off64.active", 32'(voice_active), 32'hEF);
    do_miss("off64_again", 64);
    do_miss("off50", 50);
    check("miss.active", 32'(voice_active), 32'hEF);

    // Octave extremes
    pulse_reset();
    do_write("on0", 1'b1, 0, 3, 0, 1'b1, 32'd731558);
    do_write("on127", 1'b1, 127, 13, 1, 1'b1, 32'd1122405051);
    check("ext.active", 32'(voice_active), 32'h03);

    // Back-pressure in EMIT
    cfg_ready = 1'b0;
    send_evt(1'b1, 69, lat, saw);
    check("stall.lat", 32'(lat), 32'd8);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("stall.valid", 32'(cfg_valid), 32'd1);
      check("stall.ready", 32'(evt_ready), 32'd0);
      check("stall.voice", 32'(cfg_voice), 32'd2);
      check("stall.incr", cfg_phase_incr, 32'd39370533);
    end
    check("stall.active_held", 32'(voice_active), 32'h03);
    @(negedge clk);
    cfg_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall.active", 32'(voice_active), 32'h07);
    check("stall.done", 32'(cfg_valid), 32'd0);

    // Asynchronous reset in the middle of DIVIDE (retrigger of 127 on voice 1)
    @(negedge clk);
    evt_on    = 1'b1;
    evt_note  = 7'd127;
    evt_valid = 1'b1;
    @(posedge clk);
    #1 evt_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort.pre_voice", 32'(cfg_voice), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort.cfg_valid", 32'(cfg_valid), 32'd0);
    check("abort.cfg_voice", 32'(cfg_voice), 32'd0);
    check("abort.cfg_gate", 32'(cfg_gate), 32'd0);
    check("abort.cfg_incr", cfg_phase_incr, 32'd0);
    check("abort.active", 32'(voice_active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort.ready", 32'(evt_ready), 32'd1);
    check("abort.active_after", 32'(voice_active), 32'd0);
    stray = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (cfg_valid) stray = 1'b1;
    end
    check("abort.no_cfg", 32'(stray), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator sitting between the note-event source (MIDI decode) and the oscillator bank. It accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of NUM_VOICES oscillator voices, stealing the oldest voice when all are busy. It converts the MIDI note number into the oscillators' 32-bit PHASE_INCR. It emits one configuration write (voice index, gate, phase increment) per event to the voice register bank.

## Interface
- NUM_VOICES, 8: number of oscillator voices managed; power of two, 2..16.
- VW, $clog2(NUM_VOICES): voice index width (derived).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- evt_valid  in  1  event present.
- evt_ready  out  1  allocator can accept an event.
- evt_on  in  1  1 = note-on, 0 = note-off.
- evt_note  in  7  MIDI note number 0..127.
- cfg_valid  out  1  configuration write pending.
- cfg_ready  in  1  voice bank accepts write.
- cfg_voice  out  VW  target voice index.
- cfg_gate  out  1  1 = start/retrigger voice, 0 = release voice.
- cfg_phase_incr  out  32  oscillator PHASE_INCR for that voice.
- voice_active  out  NUM_VOICES  per-voice gate state (registered).

## Operation
- Per-voice state: active bit, note[6:0], incr[31:0], age[3:0] (saturates at 15).
- FSM: IDLE -> SEARCH -> (DIVIDE -> CALC ->) EMIT -> IDLE.
- IDLE: evt_ready=1. On evt_valid&&evt_ready, latch evt_on/evt_note and go to SEARCH. evt_ready=0 in every other state; upstream holds its event.
- SEARCH, note-on: pick the target voice in this priority order:
  - an active voice with a matching note (retrigger);
  - otherwise the lowest-index inactive voice;
  - otherwise the active voice with maximum age, lowest index on ties (steal).
  - Then go to DIVIDE.
- SEARCH, note-off: target is the lowest-index active voice with a matching note. Go to EMIT with cfg_gate=0 and cfg_phase_incr = that voice's stored incr. If no voice matches, the event is dropped: return to IDLE, no cfg write.
- DIVIDE: rem=note, oct=0 on entry. Each cycle, if rem>=12 then rem-=12 and oct+=1; otherwise go to CALC. Takes oct+1 cycles.
- CALC: incr = BASE[rem] >> (10-oct).
  - BASE[s] = floor(f(120+s) * 2^32 / 48000), where f(m) = 440*2^((m-69)/12). This is a 12-entry constant ROM.
  - BASE[9] = 1259857073.
- EMIT: cfg_valid=1. cfg_voice, cfg_gate and cfg_phase_incr stay stable until cfg_ready.
- On the handshake edge (cfg_valid&&cfg_ready), the voice table updates and the FSM returns to IDLE.
  - Note-on: target becomes active, note and incr are stored, target age=0, every other active voice age+=1 (saturating).
  - Note-off: target becomes inactive; ages unchanged.
- A steal emits only the new note-on to the stolen voice; no separate gate-off is issued.

## Timing
- Reset (async assert, sync release): state=IDLE, cfg_valid=0, cfg_voice=0, cfg_gate=0, cfg_phase_incr=0, voice_active=0, all voice notes, incrs and ages 0.
- Reset assertion mid-event aborts the event; no cfg write occurs.
- evt_ready is combinational from state: 1 in IDLE, including immediately after reset release.
- The event is accepted at edge E0.
  - Note-on: cfg_valid rises after edge E0+oct+3. Note 69 (oct 5): after E0+8. Note 0: after E0+3. Note 127 (oct 10): after E0+13.
  - Note-off hit: cfg_valid rises after E0+2.
  - Note-off miss: evt_ready returns to 1 after E0+2.
- voice_active reflects the table update the cycle after the cfg handshake. The next event can be accepted the cycle after that handshake.
- Only one event is in flight at a time; there are no simultaneous events.

## Test plan
- Reset, then note-on 69 with cfg_ready=1: cfg_valid after 8 cycles, cfg_voice=0, gate=1, incr=39370533. voice_active=0x01.
- Note-on 60,62,64 then note-off 62 -> voices 0,1,2 allocated; the off writes voice 1 with gate=0 and incr equal to its note-on incr; voice_active=0x05.
- Fill all 8 voices with notes 60..67, then note-on 72 -> steals voice 0 (age 7). A following note-on 74 steals voice 1.
- Note-on 64 twice -> both writes target the same voice, only one voice is active, and that voice's age resets to 0.
- Note-off 50 with no voice holding note 50 -> no cfg_valid, and evt_ready high again 2 cycles after accept.
- Hold cfg_ready=0 for 5 cycles in EMIT -> outputs stable and evt_ready=0. Assert rst_n=0 mid-DIVIDE -> all outputs 0 at once; after release, evt_ready=1 and voice_active=0.
